// File: rtl/hex_pair_display.sv
// -----------------------------------------------------------------------------
// hex_pair_display
//
// Display stage for the two-digit HEX PIO. The 8-bit out_port byte is
// registered, each nibble is decoded to an active-low seven-segment glyph
// (HEX1 = high nibble, HEX0 = low nibble), and both digits blink for a bounded
// interval whenever the displayed value changes. The blink gives software a
// visible acknowledgement of every write without any extra bus traffic.
//
// Parameters:
//   PRESCALE     clock cycles per blink half-period (>= 2)
//   FLASH_TICKS  half-periods per flash (>= 1); an even value ends on "show"
//
// Ports:
//   clk       in   1  system clock, single domain
//   reset     in   1  synchronous, active-high reset
//   value_in  in   8  byte from the HEX PIO out_port
//   enable    in   1  1 = display active, 0 = digits blanked, no flashing
//   hex0      out  7  low-nibble segments, active-low, bit 0 = a .. bit 6 = g
//   hex1      out  7  high-nibble segments, active-low, same bit order
//   flashing  out  1  high while a change-flash is in progress
//
// All outputs are registered and therefore lag the FSM state by one cycle.
// -----------------------------------------------------------------------------
module hex_pair_display #(
    parameter int PRESCALE    = 25_000_000,
    parameter int FLASH_TICKS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value_in,
    input  logic       enable,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic       flashing
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RW = (FLASH_TICKS > 0) ? $clog2(FLASH_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] REMAIN_LOAD = RW'(FLASH_TICKS);
    localparam logic [RW-1:0] REMAIN_LAST = RW'(1);
    localparam logic [6:0]    GLYPH_BLANK = 7'h7F;

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } state_t;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } phase_t;

    // Active-low hexadecimal glyphs, bit order g..a.
    function automatic logic [6:0] decodeNibble(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
        return glyph;
    endfunction

    logic [7:0]    value_q;
    state_t        state_q,  state_d;
    phase_t        phase_q,  phase_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic [RW-1:0] remain_q, remain_d;
    logic [6:0]    hex0_q,   hex0_d;
    logic [6:0]    hex1_q,   hex1_d;
    logic          flashing_q, flashing_d;

    logic          change;
    logic          tick;
    logic          showDigits;

    // A change compares the incoming byte with the byte already held, so it
    // is seen in the cycle before value_q picks it up.
    assign change = (value_in != value_q);
    assign tick   = (presc_q == PRESC_LAST);

    // Flash sequencing. Disable has top priority (after reset), then a fresh
    // change restarts the flash from scratch, then the prescaler advances.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        presc_d  = presc_q;
        remain_d = remain_q;

        if (!enable) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (change) begin
            state_d  = FLASH;
            phase_d  = BLANK;
            presc_d  = '0;
            remain_d = REMAIN_LOAD;
        end else if (state_q == FLASH) begin
            if (tick) begin
                presc_d  = '0;
                phase_d  = (phase_q == BLANK) ? SHOW : BLANK;
                remain_d = remain_q - RW'(1);
                if (remain_q == REMAIN_LAST) begin
                    state_d = IDLE;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Output images are built from the current state, so the visible digits
    // follow the FSM one edge later. enable is taken straight from the input
    // so that blanking and re-enable both appear one edge after they change.
    always_comb begin
        showDigits = enable && ((state_q == IDLE) || (phase_q == SHOW));
        hex1_d     = GLYPH_BLANK;
        hex0_d     = GLYPH_BLANK;
        if (showDigits) begin
            hex1_d = decodeNibble(value_q[7:4]);
            hex0_d = decodeNibble(value_q[3:0]);
        end
        flashing_d = enable && (state_q == FLASH);
    end

    // State, input and output registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q    <= '0;
            state_q    <= IDLE;
            phase_q    <= BLANK;
            presc_q    <= '0;
            remain_q   <= '0;
            hex0_q     <= GLYPH_BLANK;
            hex1_q     <= GLYPH_BLANK;
            flashing_q <= 1'b0;
        end else begin
            value_q    <= value_in;
            state_q    <= state_d;
            phase_q    <= phase_d;
            presc_q    <= presc_d;
            remain_q   <= remain_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
            flashing_q <= flashing_d;
        end
    end

    assign hex0     = hex0_q;
    assign hex1     = hex1_q;
    assign flashing = flashing_q;

endmodule

// File: tb/tb_hex_pair_display.sv
// -----------------------------------------------------------------------------
// tb_hex_pair_display
//
// Directed bench for hex_pair_display with PRESCALE = 4 and FLASH_TICKS = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Every observation is packed as {flashing, hex1, hex0} and compared against
// hand-derived expectations from the glyph table and the flash timing.
// -----------------------------------------------------------------------------
module tb_hex_pair_display;

    localparam int PRESCALE    = 4;
    localparam int FLASH_TICKS = 4;
    localparam int FLASH_LEN   = PRESCALE * FLASH_TICKS;
    localparam logic [6:0] BLK = 7'h7F;

    logic       clock;
    logic       reset;
    logic [7:0] valueIn;
    logic       enable;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic       flashing;

    int vectorCount = 0;
    int missCount   = 0;

    logic [6:0] glyphTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_pair_display #(
        .PRESCALE   (PRESCALE),
        .FLASH_TICKS(FLASH_TICKS)
    ) dut (
        .clk     (clock),
        .reset   (reset),
        .value_in(valueIn),
        .enable  (enable),
        .hex0    (hex0),
        .hex1    (hex1),
        .flashing(flashing)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive all DUT inputs at once.
    task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] val);
        reset   = rst;
        enable  = en;
        valueIn = val;
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [14:0] observed,
                               input logic [14:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed {flash,hex1,hex0}=%h required %h", tag, observed, expected);
        end
    endtask

    function automatic logic [14:0] outVec();
        return {flashing, hex1, hex0};
    endfunction

    // Expected image i cycles into a visible flash (i = 0 is the first blank).
    function automatic logic [14:0] flashImage(input int i, input logic [6:0] g1, input logic [6:0] g0);
        if (((i / PRESCALE) % 2) == 0) return {1'b1, BLK, BLK};
        return {1'b1, g1, g0};
    endfunction

    // Called one edge after the triggering change has been loaded: checks the
    // whole visible flash and the settled display after it.
    task automatic runFlash(input string tag, input logic [6:0] g1, input logic [6:0] g0);
        for (int i = 0; i < FLASH_LEN; i++) begin
            stepCycles(1);
            checkOutput($sformatf("%s_c%0d", tag, i), outVec(), flashImage(i, g1, g0));
        end
        stepCycles(1);
        checkOutput($sformatf("%s_end", tag), outVec(), {1'b0, g1, g0});
    endtask

    initial begin
        logic [7:0] prevVal;
        logic [7:0] newVal;

        // Reset with value 00: blank during reset, 40/40 right after release.
        applyStimulus(1'b1, 1'b1, 8'h00);
        stepCycles(3);
        checkOutput("reset_hold", outVec(), {1'b0, BLK, BLK});
        applyStimulus(1'b0, 1'b1, 8'h00);
        stepCycles(1);
        checkOutput("reset_release", outVec(), {1'b0, 7'h40, 7'h40});
        stepCycles(2);
        checkOutput("idle_00", outVec(), {1'b0, 7'h40, 7'h40});

        // 00 -> 3A: full flash, settles on 30/08.
        applyStimulus(1'b0, 1'b1, 8'h3A);
        stepCycles(1);
        runFlash("flash3A", 7'h30, 7'h08);

        // 3A -> 5C, then 5D six edges in: flash restarts without a gap.
        applyStimulus(1'b0, 1'b1, 8'h5C);
        stepCycles(1);
        for (int i = 0; i < 5; i++) begin
            stepCycles(1);
            checkOutput($sformatf("flash5C_c%0d", i), outVec(), flashImage(i, 7'h12, 7'h46));
        end
        applyStimulus(1'b0, 1'b1, 8'h5D);
        stepCycles(1);
        checkOutput("restart_edge1", outVec(), {1'b1, 7'h12, 7'h46});
        runFlash("flash5D", 7'h12, 7'h21);

        // Disabled: blank and no flash while the value moves to 00 then FF.
        applyStimulus(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            stepCycles(1);
            checkOutput($sformatf("dis00_c%0d", i), outVec(), {1'b0, BLK, BLK});
        end
        applyStimulus(1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            stepCycles(1);
            checkOutput($sformatf("disFF_c%0d", i), outVec(), {1'b0, BLK, BLK});
        end
        applyStimulus(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            stepCycles(1);
            checkOutput($sformatf("reenable_c%0d", i), outVec(), {1'b0, 7'h0E, 7'h0E});
        end

        // Reset mid-flash with 77 present: blank at once, flash on release.
        applyStimulus(1'b0, 1'b1, 8'h77);
        stepCycles(1);
        stepCycles(3);
        checkOutput("pre_reset_flash", outVec(), {1'b1, BLK, BLK});
        applyStimulus(1'b1, 1'b1, 8'h77);
        stepCycles(1);
        checkOutput("midflash_reset", outVec(), {1'b0, BLK, BLK});
        stepCycles(1);
        checkOutput("midflash_reset2", outVec(), {1'b0, BLK, BLK});
        applyStimulus(1'b0, 1'b1, 8'h77);
        stepCycles(1);
        checkOutput("post_reset_edge1", outVec(), {1'b0, 7'h40, 7'h40});
        runFlash("flash77", 7'h78, 7'h78);

        // Decode sweep over n*0x11.
        prevVal = 8'h77;
        for (int n = 0; n < 16; n++) begin
            newVal = 8'(n * 17);
            applyStimulus(1'b0, 1'b1, newVal);
            if (newVal == prevVal) begin
                stepCycles(2);
                checkOutput($sformatf("sweep%0d_steady", n), outVec(),
                            {1'b0, glyphTab[n], glyphTab[n]});
            end else begin
                stepCycles(1);
                runFlash($sformatf("sweep%0d", n), glyphTab[n], glyphTab[n]);
            end
            prevVal = newVal;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
